neuron_fst_sched: RTL and testbench

// Sequencer and output buffer for first-spike-time (FST) neuron mode.
// - Accepts one event per cycle (ARM / TICK / SPIKE) over a valid/ready handshake.
// - Owns the FST state registers (armed, fst_t, fst_last_t).
// - Queues the resulting 8-bit tokens in a small FIFO for the serialiser.
// - Events that would emit a token into a full buffer are back-pressured, never dropped.

---
 rtl/neuron_fst_sched_if.sv | 20 ++
 rtl/neuron_fst_sched.sv | 145 ++++++++++++++
 tb/tb_neuron_fst_sched.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_fst_sched_if.sv
// Event-in / token-out handshake bundle for the FST sequencer.
// Both directions use valid/ready: a transfer happens on a rising clk edge where valid & ready are both high.
interface neuron_fst_sched_if;
  logic       ev_valid;
  logic [1:0] ev_kind;
  logic       ev_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output ev_valid, ev_kind, out_ready,
    input  ev_ready, out_valid, out_data
  );

  modport slave (
    input  ev_valid, ev_kind, out_ready,
    output ev_ready, out_valid, out_data
  );
endinterface

// File: rtl/neuron_fst_sched.sv
// First-spike-time sequencer: tracks time since ARM, captures it on SPIKE,
// and queues 8-bit tokens in a small FIFO for the serialiser.
module neuron_fst_sched #(
  parameter int OUT_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               stream_act,
  neuron_fst_sched_if.slave  bus,
  output logic               post_spike_pulse,
  output logic [1:0]         fsm_state,
  output logic [7:0]         fst_t,
  output logic [7:0]         fst_last_t
);

  localparam int              AW      = $clog2(OUT_DEPTH);
  localparam logic [AW:0]     L_DEPTH = (AW+1)'(OUT_DEPTH);
  localparam logic [2:0]      NEURON_TYPE_SPIKE = 3'd1;
  localparam logic [2:0]      NEURON_TYPE_ACT   = 3'd2;
  localparam logic [1:0]      EV_TICK  = 2'b00;
  localparam logic [1:0]      EV_SPIKE = 2'b01;
  localparam logic [1:0]      EV_ARM   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t          r_state;
  logic [7:0]      r_fst_t;
  logic [7:0]      r_fst_last_t;
  logic            r_pulse;
  logic [7:0]      r_mem [OUT_DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;

  logic            w_ev_ready;
  logic            w_accept;
  logic            w_armed;
  logic            w_pop;
  logic            w_push;
  logic [7:0]      w_push_data;
  logic [7:0]      w_fst_inc;

  // Readiness looks only at the registered count, so a pop never frees a slot in the same cycle.
  assign w_ev_ready = !rst && !clear && (r_count < L_DEPTH);
  assign w_accept   = bus.ev_valid && w_ev_ready;
  assign w_armed    = (r_state == S_ARMED);
  assign w_pop      = (r_count != '0) && bus.out_ready && !clear;

  always_comb begin
    w_fst_inc   = (r_fst_t == 8'hFF) ? 8'hFF : r_fst_t + 8'd1;
    w_push      = 1'b0;
    w_push_data = 8'h00;
    if (w_accept) begin
      case (bus.ev_kind)
        EV_TICK: begin
          if (stream_act) begin
            w_push      = 1'b1;
            w_push_data = {1'b1, NEURON_TYPE_ACT,
                           w_armed ? w_fst_inc[3:0] : r_fst_last_t[3:0]};
          end
        end
        EV_SPIKE: begin
          if (w_armed) begin
            w_push      = 1'b1;
            w_push_data = {1'b1, NEURON_TYPE_SPIKE, r_fst_t[3:0]};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_fst_t      <= 8'h00;
      r_fst_last_t <= 8'h00;
      r_pulse      <= 1'b0;
    end else if (clear) begin
      r_state      <= S_IDLE;
      r_fst_t      <= 8'h00;
      r_fst_last_t <= 8'h00;
      r_pulse      <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (w_accept) begin
        case (bus.ev_kind)
          EV_ARM: begin
            r_state <= S_ARMED;
            r_fst_t <= 8'h00;
          end
          EV_SPIKE: begin
            if (w_armed) begin
              r_state      <= S_DONE;
              r_fst_last_t <= r_fst_t;
              r_pulse      <= 1'b1;
            end
          end
          EV_TICK: begin
            if (w_armed) r_fst_t <= w_fst_inc;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ev_ready     = w_ev_ready;
  assign bus.out_valid    = (r_count != '0);
  assign bus.out_data     = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
  assign post_spike_pulse = r_pulse;
  assign fsm_state        = r_state;
  assign fst_t            = r_fst_t;
  assign fst_last_t       = r_fst_last_t;

endmodule

// File: tb/tb_neuron_fst_sched.sv
// Directed bench for neuron_fst_sched: hand-computed tokens go into exp_q,
// a negedge monitor pops them as the consumer takes each token.
module tb_neuron_fst_sched;

  localparam logic [1:0] EV_TICK  = 2'b00;
  localparam logic [1:0] EV_SPIKE = 2'b01;
  localparam logic [1:0] EV_ARM   = 2'b10;
  localparam logic [1:0] EV_RSVD  = 2'b11;
  // Token encodings: {1, type, payload}, SPIKE type 1, ACT type 2
  localparam logic [7:0] TOK_SPK_3 = 8'h93;
  localparam logic [7:0] TOK_SPK_F = 8'h9F;
  localparam logic [7:0] TOK_SPK_5 = 8'h95;
  localparam logic [7:0] TOK_ACT_1 = 8'hA1;
  localparam logic [7:0] TOK_ACT_2 = 8'hA2;
  localparam logic [7:0] TOK_ACT_3 = 8'hA3;
  localparam logic [7:0] TOK_ACT_4 = 8'hA4;
  localparam logic [7:0] TOK_ACT_5 = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       stream_act = 1'b0;
  logic       post_spike_pulse;
  logic [1:0] fsm_state;
  logic [7:0] fst_t;
  logic [7:0] fst_last_t;

  neuron_fst_sched_if bus ();

  neuron_fst_sched #(.OUT_DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .clear            (clear),
    .stream_act       (stream_act),
    .bus              (bus),
    .post_spike_pulse (post_spike_pulse),
    .fsm_state        (fsm_state),
    .fst_t            (fst_t),
    .fst_last_t       (fst_last_t)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !clear && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("tok_extra", {24'h0, bus.out_data}, 32'h0);
      end else begin
        m_exp = exp_q.pop_front();
        check("tok_data", {24'h0, bus.out_data}, {24'h0, m_exp});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ev(input logic [1:0] k);
    int b;
    b = 0;
    bus.ev_valid = 1'b1;
    bus.ev_kind  = k;
    @(negedge clk);
    while (!bus.ev_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (b >= 100) check("ev_timeout", {31'h0, bus.ev_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.ev_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.ev_valid  = 1'b0;
    bus.ev_kind   = EV_TICK;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    bus.ev_valid = 1'b1;
    bus.ev_kind  = EV_ARM;
    @(negedge clk);
    check("rst_ev_ready", {31'h0, bus.ev_ready}, 32'h0);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_out_data", {24'h0, bus.out_data}, 32'h0);
    check("rst_fsm", {30'h0, fsm_state}, 32'h0);
    check("rst_fst_t", {24'h0, fst_t}, 32'h0);
    check("rst_pulse", {31'h0, post_spike_pulse}, 32'h0);
    bus.ev_valid = 1'b0;
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // 1: ARM, 3 TICK, SPIKE
    send_ev(EV_ARM);
    check("t1_fsm_armed", {30'h0, fsm_state}, 32'h1);
    check("t1_fst_zero", {24'h0, fst_t}, 32'h0);
    repeat (3) send_ev(EV_TICK);
    check("t1_fst_3", {24'h0, fst_t}, 32'h3);
    check("t1_no_tok", {31'h0, bus.out_valid}, 32'h0);
    exp_q.push_back(TOK_SPK_3);
    send_ev(EV_SPIKE);
    check("t1_pulse_hi", {31'h0, post_spike_pulse}, 32'h1);
    check("t1_fsm_done", {30'h0, fsm_state}, 32'h2);
    check("t1_last_t", {24'h0, fst_last_t}, 32'h3);
    check("t1_lat", {31'h0, bus.out_valid}, 32'h1);
    check("t1_head", {24'h0, bus.out_data}, {24'h0, TOK_SPK_3});
    step();
    check("t1_pulse_lo", {31'h0, post_spike_pulse}, 32'h0);
    check("t1_drained", {31'h0, bus.out_valid}, 32'h0);

    // 2: streamed ACT tokens
    stream_act = 1'b1;
    send_ev(EV_ARM);
    check("t2_arm_no_tok", {31'h0, bus.out_valid}, 32'h0);
    exp_q.push_back(TOK_ACT_1);
    send_ev(EV_TICK);
    check("t2_lat1", {31'h0, bus.out_valid}, 32'h1);
    exp_q.push_back(TOK_ACT_2);
    send_ev(EV_TICK);
    check("t2_lat2", {31'h0, bus.out_valid}, 32'h1);
    check("t2_head2", {24'h0, bus.out_data}, {24'h0, TOK_ACT_2});
    step();
    check("t2_drained", {31'h0, bus.out_valid}, 32'h0);

    // 3: back-pressure at full buffer
    bus.out_ready = 1'b0;
    exp_q.push_back(TOK_ACT_3);
    send_ev(EV_TICK);
    exp_q.push_back(TOK_ACT_4);
    send_ev(EV_TICK);
    check("t3_hold_head", {24'h0, bus.out_data}, {24'h0, TOK_ACT_3});
    exp_q.push_back(TOK_ACT_5);
    bus.ev_valid = 1'b1;
    bus.ev_kind  = EV_TICK;
    @(negedge clk);
    check("t3_full_block", {31'h0, bus.ev_ready}, 32'h0);
    step();
    check("t3_held_tick", {24'h0, fst_t}, 32'h4);
    check("t3_head_stable", {24'h0, bus.out_data}, {24'h0, TOK_ACT_3});
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t3_no_same_cyc", {31'h0, bus.ev_ready}, 32'h0);
    step();
    @(negedge clk);
    check("t3_ready_after", {31'h0, bus.ev_ready}, 32'h1);
    step();
    bus.ev_valid = 1'b0;
    check("t3_accepted", {24'h0, fst_t}, 32'h5);
    step();
    step();
    check("t3_drained", {31'h0, bus.out_valid}, 32'h0);
    check("t3_q_empty", exp_q.size(), 32'h0);

    // 4: saturation
    stream_act = 1'b0;
    send_ev(EV_ARM);
    check("t4_restart", {24'h0, fst_t}, 32'h0);
    for (int i = 0; i < 255; i++) send_ev(EV_TICK);
    check("t4_fst_255", {24'h0, fst_t}, 32'hFF);
    for (int i = 0; i < 5; i++) send_ev(EV_TICK);
    check("t4_fst_sat", {24'h0, fst_t}, 32'hFF);
    exp_q.push_back(TOK_SPK_F);
    send_ev(EV_SPIKE);
    check("t4_last_t", {24'h0, fst_last_t}, 32'hFF);
    step();

    // 5: DONE behaviour and reserved kind
    send_ev(EV_ARM);
    repeat (5) send_ev(EV_TICK);
    exp_q.push_back(TOK_SPK_5);
    send_ev(EV_SPIKE);
    step();
    stream_act = 1'b1;
    exp_q.push_back(TOK_ACT_5);
    send_ev(EV_TICK);
    check("t5_fst_hold", {24'h0, fst_t}, 32'h5);
    check("t5_act_last", {24'h0, bus.out_data}, {24'h0, TOK_ACT_5});
    step();
    send_ev(EV_SPIKE);
    check("t5_no_pulse", {31'h0, post_spike_pulse}, 32'h0);
    check("t5_no_tok", {31'h0, bus.out_valid}, 32'h0);
    check("t5_fsm_done", {30'h0, fsm_state}, 32'h2);
    send_ev(EV_RSVD);
    check("t5_rsvd_fsm", {30'h0, fsm_state}, 32'h2);
    check("t5_rsvd_no_tok", {31'h0, bus.out_valid}, 32'h0);
    check("t5_rsvd_last", {24'h0, fst_last_t}, 32'h5);

    // 6a: clear with two tokens queued
    bus.out_ready = 1'b0;
    send_ev(EV_ARM);
    exp_q.push_back(TOK_ACT_1);
    send_ev(EV_TICK);
    exp_q.push_back(TOK_ACT_2);
    send_ev(EV_TICK);
    check("t6_two_queued", {31'h0, bus.out_valid}, 32'h1);
    clear = 1'b1;
    bus.ev_valid = 1'b1;
    bus.ev_kind  = EV_ARM;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t6_clr_ready", {31'h0, bus.ev_ready}, 32'h0);
    step();
    clear = 1'b0;
    bus.ev_valid = 1'b0;
    exp_q.delete();
    check("t6_clr_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("t6_clr_out_data", {24'h0, bus.out_data}, 32'h0);
    check("t6_clr_fsm", {30'h0, fsm_state}, 32'h0);
    check("t6_clr_fst_t", {24'h0, fst_t}, 32'h0);
    check("t6_clr_last_t", {24'h0, fst_last_t}, 32'h0);

    // 6b: clear with space left in the buffer still blocks the event
    bus.out_ready = 1'b0;
    send_ev(EV_ARM);
    exp_q.push_back(TOK_ACT_1);
    send_ev(EV_TICK);
    clear = 1'b1;
    bus.ev_valid = 1'b1;
    bus.ev_kind  = EV_TICK;
    @(negedge clk);
    check("t6_clr_ready_1", {31'h0, bus.ev_ready}, 32'h0);
    step();
    clear = 1'b0;
    bus.ev_valid = 1'b0;
    exp_q.delete();
    check("t6_clr_fst_1", {24'h0, fst_t}, 32'h0);
    check("t6_clr_empty_1", {31'h0, bus.out_valid}, 32'h0);

    // 6c: async reset mid-window with a SPIKE pending
    send_ev(EV_ARM);
    exp_q.push_back(TOK_ACT_1);
    send_ev(EV_TICK);
    exp_q.push_back(TOK_ACT_2);
    send_ev(EV_TICK);
    bus.ev_valid = 1'b1;
    bus.ev_kind  = EV_SPIKE;
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_ready", {31'h0, bus.ev_ready}, 32'h0);
    check("t6_rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("t6_rst_fsm", {30'h0, fsm_state}, 32'h0);
    check("t6_rst_fst_t", {24'h0, fst_t}, 32'h0);
    @(negedge clk);
    check("t6_rst_ready_neg", {31'h0, bus.ev_ready}, 32'h0);
    step();
    rst = 1'b0;
    bus.ev_valid = 1'b0;
    exp_q.delete();
    check("t6_rel_pulse", {31'h0, post_spike_pulse}, 32'h0);
    check("t6_rel_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("t6_rel_fsm", {30'h0, fsm_state}, 32'h0);
    step();
    check("t6_rel_pulse2", {31'h0, post_spike_pulse}, 32'h0);

    bus.out_ready = 1'b1;
    repeat (3) step();
    check("final_q_empty", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
